// File: rtl/midori64_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | midori64_pkg : shared widths, round constants and FSM encoding for the      |
// |                Midori64 masked key schedule.                               |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
package midori64_pkg;

    localparam int KEY_W  = 64;
    localparam int MKEY_W = 128;

    // Bit 15 of each constant belongs to nibble 0 (most significant nibble).
    localparam logic [15:0] ALPHA [0:14] = '{
        16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F,
        16'hD170, 16'h0266, 16'h0BCC, 16'h9481, 16'h40B8,
        16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WK_IN  = 2'd1,
        ST_ROUND  = 2'd2,
        ST_WK_OUT = 2'd3
    } state_t;

    function automatic logic [KEY_W-1:0] expand_alpha(input logic [15:0] a);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[4*j] = a[j];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midori64_rk_share.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | midori64_rk_share : per-share key select, whitening XOR and round-constant  |
// |                     add (constant only on the share built with ADD_RC=1).  |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module midori64_rk_share
    import midori64_pkg::*;
#(
    parameter bit ADD_RC = 1'b0
) (
    input  logic [KEY_W-1:0] i_k0,
    input  logic [KEY_W-1:0] i_k1,
    input  logic             i_wk,
    input  logic             i_odd,
    input  logic [15:0]      i_alpha,
    output logic [KEY_W-1:0] o_rk
);

    logic [KEY_W-1:0] w_sel;
    logic [KEY_W-1:0] w_rc;

    always_comb begin
        w_sel = i_wk ? (i_k0 ^ i_k1) : (i_odd ? i_k1 : i_k0);
        w_rc  = expand_alpha(i_alpha) & {KEY_W{ADD_RC && !i_wk}};
        o_rk  = w_sel ^ w_rc;
    end

endmodule
`default_nettype wire

// File: rtl/midori64_key_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | midori64_key_schedule : back-pressured producer of masked Midori64 keys    |
// |   (WK, RK0..RK(NR-1), WK). Optional share refresh: define KEY_REFRESH_EN.   |
// | Revision              : 1.0                                                 |
// +----------------------------------------------------------------------------+
module midori64_key_schedule
    import midori64_pkg::*;
#(
    parameter int SHARES = 3,
    parameter int NR     = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       key_valid,
    output logic                       key_ready,
    input  logic [MKEY_W*SHARES-1:0]   key_in,
`ifdef KEY_REFRESH_EN
    // Collapses to a single unused bit when SHARES=1.
    input  logic [(SHARES > 1 ? MKEY_W*(SHARES-1) : 1)-1:0] rnd,
`endif
    output logic                       rk_valid,
    input  logic                       rk_ready,
    output logic [KEY_W*SHARES-1:0]    rk_data,
    output logic [3:0]                 rk_round,
    output logic                       rk_last,
    output logic                       busy
);

    localparam logic [3:0] LAST_IDX   = 4'(NR - 1);
    // NR=15 gives a final tag of 16, which wraps to 0 in the 4-bit field.
    localparam logic [3:0] WK_OUT_TAG = 4'(NR + 1);

    state_t                      r_state;
    state_t                      w_next_state;
    logic [3:0]                  r_idx;
    logic [3:0]                  w_next_idx;
    logic [MKEY_W*SHARES-1:0]    r_key;
    logic [MKEY_W*SHARES-1:0]    w_next_key;
    logic [MKEY_W*SHARES-1:0]    w_rmask;

    logic                        r_key_ready;
    logic                        r_busy;
    logic                        r_rk_valid;
    logic [KEY_W*SHARES-1:0]     r_rk_data;
    logic [3:0]                  r_rk_round;
    logic                        r_rk_last;

    logic                        w_rk_hs;
    logic                        w_key_hs;
    logic                        w_out_wk;
    logic                        w_out_odd;
    logic [3:0]                  w_out_round;
    logic                        w_out_last;
    logic [15:0]                 w_alpha;
    logic [KEY_W*SHARES-1:0]     w_rk_data;

    assign w_rk_hs  = r_rk_valid & rk_ready;
    assign w_key_hs = (r_state == ST_IDLE) & key_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and round-counter logic
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (key_valid) begin
                    w_next_state = ST_WK_IN;
                    w_next_idx   = 4'd0;
                end
            end
            ST_WK_IN: begin
                if (w_rk_hs) begin
                    w_next_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (w_rk_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_next_state = ST_WK_OUT;
                        w_next_idx   = 4'd0;
                    end else begin
                        w_next_idx = r_idx + 4'd1;
                    end
                end
            end
            ST_WK_OUT: begin
                if (w_rk_hs) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_idx   = 4'd0;
            end
        endcase
    end

    // Share 0 absorbs the XOR of all fresh randomness so the unmasked key is preserved.
    always_comb begin
        w_rmask = '0;
`ifdef KEY_REFRESH_EN
        for (int s = 1; s < SHARES; s++) begin
            w_rmask[MKEY_W*s +: MKEY_W] = rnd[MKEY_W*(s-1) +: MKEY_W];
            w_rmask[0 +: MKEY_W]        = w_rmask[0 +: MKEY_W] ^ rnd[MKEY_W*(s-1) +: MKEY_W];
        end
`endif
    end

    always_comb begin
        w_next_key = r_key;
        if (w_key_hs) begin
            w_next_key = key_in;
        end else if (w_rk_hs) begin
            w_next_key = r_key ^ w_rmask;
        end
    end

    // Output decode for the beat presented next cycle
    always_comb begin
        w_out_wk    = 1'b1;
        w_out_odd   = 1'b0;
        w_out_round = 4'd0;
        w_out_last  = 1'b0;
        case (w_next_state)
            ST_ROUND: begin
                w_out_wk    = 1'b0;
                w_out_odd   = w_next_idx[0];
                w_out_round = w_next_idx + 4'd1;
            end
            ST_WK_OUT: begin
                w_out_round = WK_OUT_TAG;
                w_out_last  = 1'b1;
            end
            default: begin
                w_out_wk = 1'b1;
            end
        endcase
    end

    assign w_alpha = (w_next_idx < 4'd15) ? ALPHA[w_next_idx] : 16'h0000;

    for (genvar s = 0; s < SHARES; s++) begin : g_share
        midori64_rk_share #(
            .ADD_RC (s == 0)
        ) u_rk_share (
            .i_k0    (w_next_key[MKEY_W*s + KEY_W +: KEY_W]),
            .i_k1    (w_next_key[MKEY_W*s +: KEY_W]),
            .i_wk    (w_out_wk),
            .i_odd   (w_out_odd),
            .i_alpha (w_alpha),
            .o_rk    (w_rk_data[KEY_W*s +: KEY_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= 4'd0;
            r_key       <= '0;
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rk_valid  <= 1'b0;
            r_rk_data   <= '0;
            r_rk_round  <= 4'd0;
            r_rk_last   <= 1'b0;
        end else begin
            r_idx       <= w_next_idx;
            r_key       <= w_next_key;
            r_key_ready <= (w_next_state == ST_IDLE);
            r_busy      <= (w_next_state != ST_IDLE);
            r_rk_valid  <= (w_next_state != ST_IDLE);
            r_rk_data   <= (w_next_state == ST_IDLE) ? '0 : w_rk_data;
            r_rk_round  <= w_out_round;
            r_rk_last   <= w_out_last;
        end
    end

    assign key_ready = r_key_ready;
    assign busy      = r_busy;
    assign rk_valid  = r_rk_valid;
    assign rk_data   = r_rk_data;
    assign rk_round  = r_rk_round;
    assign rk_last   = r_rk_last;

endmodule
`default_nettype wire

// File: tb/tb_midori64_key_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_midori64_key_schedule : randomized self-checking bench with a beat-level |
// |                            reference model of the masked key stream.       |
// | Revision                 : 1.0                                              |
// +----------------------------------------------------------------------------+
module tb_midori64_key_schedule;

    localparam int SHARES = 3;
    localparam int NR     = 15;
    localparam int NB     = NR + 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    key_valid = 1'b0;
    logic                    key_ready;
    logic [128*SHARES-1:0]   key_in = '0;
    logic                    rk_valid;
    logic                    rk_ready = 1'b0;
    logic [64*SHARES-1:0]    rk_data;
    logic [3:0]              rk_round;
    logic                    rk_last;
    logic                    busy;

    always #5 clk = ~clk;

    midori64_key_schedule #(
        .SHARES (SHARES),
        .NR     (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    logic [15:0] alpha_tbl [0:14] = '{
        16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F,
        16'hD170, 16'h0266, 16'h0BCC, 16'h9481, 16'h40B8,
        16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90
    };

    typedef struct packed {
        logic [64*SHARES-1:0] data;
        logic [3:0]           tag;
        logic                 last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          t_last = 0;
    int          t_key = 0;
    logic [63:0] cap_x  [0:NB-1];
    logic [63:0] cap_s0 [0:NB-1];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Nibble n (0 = most significant) carries alpha bit (15-n) in its LSB.
    function automatic logic [63:0] rc64(input int r);
        logic [63:0] v;
        logic [15:0] a;
        a = alpha_tbl[r];
        v = '0;
        for (int n = 0; n < 16; n++) v = {v[59:0], 3'b000, a[15-n]};
        return v;
    endfunction

    function automatic logic [63:0] unshare(input logic [64*SHARES-1:0] d);
        logic [63:0] x;
        x = '0;
        for (int s = 0; s < SHARES; s++) x ^= d[64*s +: 64];
        return x;
    endfunction

    function automatic void push_stream(input logic [128*SHARES-1:0] k);
        beat_t b;
        logic [63:0] k0, k1, d;
        for (int i = 0; i < NB; i++) begin
            for (int s = 0; s < SHARES; s++) begin
                k0 = k[128*s + 64 +: 64];
                k1 = k[128*s +: 64];
                if (i == 0 || i == NB - 1) d = k0 ^ k1;
                else begin
                    d = (((i - 1) % 2) == 0) ? k0 : k1;
                    if (s == 0) d ^= rc64(i - 1);
                end
                b.data[64*s +: 64] = d;
            end
            b.tag  = 4'(i);
            b.last = (i == NB - 1);
            exp_q.push_back(b);
        end
    endfunction

    function automatic logic [128*SHARES-1:0] share_key(input logic [63:0] k0, input logic [63:0] k1);
        logic [128*SHARES-1:0] r;
        logic [127:0] acc;
        acc = {k0, k1};
        for (int s = 1; s < SHARES; s++) begin
            r[128*s +: 128] = {$urandom, $urandom, $urandom, $urandom};
            acc ^= r[128*s +: 128];
        end
        r[127:0] = acc;
        return r;
    endfunction

    // Per-cycle compare against the model, then advance the model on the coming edge
    initial begin
        logic [64*SHARES-1:0] prev_data;
        logic [3:0]           prev_round;
        logic                 prev_stall;
        logic                 was_empty;
        beat_t                f;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_round = '0;
        forever begin
            @(negedge clk);
            cyc++;
            was_empty = (exp_q.size() == 0);
            chk("rk_valid", rk_valid, !was_empty);
            chk("key_ready", key_ready, was_empty);
            chk("busy", busy, !was_empty);
            if (rk_valid && !was_empty) begin
                f = exp_q[0];
                chk("rk_data", rk_data, f.data);
                chk("rk_round", rk_round, f.tag);
                chk("rk_last", rk_last, f.last);
            end
            if (prev_stall) begin
                chk("stall_data", rk_data, prev_data);
                chk("stall_round", rk_round, prev_round);
            end
            prev_data  = rk_data;
            prev_round = rk_round;
            if (!rst_n) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                prev_stall = rk_valid && !rk_ready;
                if (rk_valid && rk_ready && !was_empty) begin
                    if (hs_count < NB) begin
                        cap_x[hs_count]  = unshare(rk_data);
                        cap_s0[hs_count] = rk_data[63:0];
                    end
                    hs_count++;
                    if (exp_q[0].last) t_last = cyc;
                    void'(exp_q.pop_front());
                end
                if (was_empty && key_valid) begin
                    push_stream(key_in);
                    hs_count = 0;
                    t_key    = cyc;
                end
            end
        end
    end

    task automatic start_key(input logic [128*SHARES-1:0] k, input bit hold);
        key_in    = k;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        @(posedge clk); #1;
        if (!hold) key_valid = 1'b0;
    endtask

    task automatic run_stream(input bit stall, output int cycles);
        bit done;
        done   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (!busy) done = 1'b1;
            else rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!done) begin
            errors++;
            $display("FAIL stream_timeout cycles=%0d", cycles);
        end
    endtask

    initial begin
        int cycles;
        logic [63:0] nz;
        bit hit;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_key_ready", key_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rk_valid", rk_valid, 1'b0);
        chk("reset_rk_data", rk_data, '0);
        chk("reset_rk_round", rk_round, 4'd0);
        chk("reset_rk_last", rk_last, 1'b0);

        // All-zero key: only round constants appear
        @(posedge clk); #1;
        start_key('0, 1'b0);
        run_stream(1'b0, cycles);
        chk("zero_cycles", cycles, NB);
        chk("zero_beats", hs_count, NB);
        chk("zero_beat0", cap_x[0], 64'h0);
        chk("zero_beat16", cap_x[NB-1], 64'h0);
        chk("zero_beat1", cap_s0[1], 64'h0001010110110011);
        chk("zero_beat15", cap_x[15], 64'h1101111110010000);
        nz = '0;
        for (int b = 0; b < NB; b++) nz |= cap_x[b] & ~64'h1111111111111111;
        chk("zero_nibble_msbs", nz, 64'h0);

        // Known master key, randomly shared
        start_key(share_key(64'h0123456789ABCDEF, 64'hFEDCBA9876543210), 1'b0);
        run_stream(1'b0, cycles);
        chk("known_beats", hs_count, NB);
        chk("known_wk", cap_x[0], 64'hFFFFFFFFFFFFFFFF);
        chk("known_rk0", cap_x[1], 64'h0122446699BACDFE);
        chk("known_rk1", cap_x[2], 64'hFEDCBA9876543210 ^ 64'h0111100011000000);

        // Random keys with random back-pressure
        for (int t = 0; t < 4; t++) begin
            start_key(share_key({$urandom, $urandom}, {$urandom, $urandom}), 1'b0);
            run_stream(1'b1, cycles);
            chk("stall_beats", hs_count, NB);
        end

        // key_valid held through a stream while key_in changes
        start_key(share_key({$urandom, $urandom}, {$urandom, $urandom}), 1'b1);
        key_in = share_key({$urandom, $urandom}, {$urandom, $urandom});
        run_stream(1'b0, cycles);
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("next_key_gap", t_key - t_last, 1);
        chk("next_key_busy", busy, 1'b1);
        run_stream(1'b1, cycles);
        chk("held_beats", hs_count, NB);

        // Reset in the middle of a stream
        start_key(share_key({$urandom, $urandom}, {$urandom, $urandom}), 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk); #1;
            if (rk_round == 4'd7) hit = 1'b1;
        end
        chk("reached_beat7", hit, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", rk_valid, 1'b0);
        chk("mid_rst_key_ready", key_ready, 1'b1);
        chk("mid_rst_data", rk_data, '0);
        chk("mid_rst_busy", busy, 1'b0);
        start_key(share_key({$urandom, $urandom}, {$urandom, $urandom}), 1'b0);
        chk("restart_valid", rk_valid, 1'b1);
        chk("restart_round", rk_round, 4'd0);
        run_stream(1'b1, cycles);
        chk("restart_beats", hs_count, NB);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
